// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC sequencer.
// Holds the FSM state enum and the modular sample-address helper.
package fir_pkg;

    localparam int TAPS_DEF    = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int MAC_LAT_DEF = 2;
    localparam int MAX_AW      = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        DONE
    } state_e;

    // Newest sample sits at base; tap k reads k samples back, wrapping.
    function automatic logic [MAX_AW-1:0] rd_addr(
        input logic [MAX_AW-1:0] base,
        input logic [MAX_AW-1:0] tap
    );
        return base - tap;
    endfunction

endpackage

// File: rtl/fir_valid_pipe.sv
// Delays the per-tap issue flag by the MAC datapath latency.
// Its output is the accumulator enable.
module fir_valid_pipe #(
    parameter int MAC_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic acc_en
);

    logic [MAC_LAT-1:0] pipe_q;
    logic [MAC_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | MAC_LAT'(issue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign acc_en = pipe_q[MAC_LAT-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexes one MAC datapath over all FIR taps per accepted sample.
// Sample history lives in a circular memory addressed by wptr.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = TAPS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              input_valid,
    output logic              input_ready,
    output logic              sample_we,
    output logic [ADDR_W-1:0] sample_waddr,
    output logic [ADDR_W-1:0] sample_raddr,
    output logic [ADDR_W-1:0] coef_raddr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              output_valid,
    output logic              busy
);

    localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] wptr_eff;
    logic [ADDR_W:0]   fill_eff;
    logic              issue;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        base_d       = base_q;
        tap_d        = tap_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        wptr_eff     = wptr_q;
        fill_eff     = fill_q;
        issue        = 1'b0;
        input_ready  = 1'b0;
        sample_we    = 1'b0;
        sample_waddr = '0;
        sample_raddr = '0;
        coef_raddr   = '0;
        acc_clr      = 1'b0;
        output_valid = 1'b0;
        busy         = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                input_ready = 1'b1;
                // A flush takes effect before a same-cycle accept.
                if (clear) begin
                    wptr_eff = '0;
                    fill_eff = '0;
                    wptr_d   = '0;
                    fill_d   = '0;
                end
                if (input_valid) begin
                    sample_we    = 1'b1;
                    sample_waddr = wptr_eff;
                    acc_clr      = 1'b1;
                    base_d       = wptr_eff;
                    tap_d        = '0;
                    fill_d       = (fill_eff == (ADDR_W+1)'(TAPS)) ?
                                   fill_eff : fill_eff + 1'b1;
                    state_d      = MAC;
                end
            end
            MAC: begin
                coef_raddr   = tap_q;
                sample_raddr = ADDR_W'(rd_addr(MAX_AW'(base_q),
                                               MAX_AW'(tap_q)));
                // Unwritten history is masked rather than read as stale data.
                issue        = ({1'b0, tap_q} < fill_q);
                tap_d        = tap_q + 1'b1;
                if (tap_q == ADDR_W'(TAPS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(MAC_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                output_valid = 1'b1;
                wptr_d       = wptr_q + 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            base_q  <= '0;
            tap_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            base_q  <= base_d;
            tap_q   <= tap_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    fir_valid_pipe #(
        .MAC_LAT(MAC_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .issue (issue),
        .acc_en(acc_en)
    );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed table-driven bench for the FIR MAC sequencer.
// A second instance covers the TAPS=4 / MAC_LAT=1 build.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       input_valid = 1'b0;
    logic       input_ready, sample_we, acc_clr, acc_en;
    logic       output_valid, busy;
    logic [3:0] sample_waddr, sample_raddr, coef_raddr;

    logic       clear4 = 1'b0;
    logic       valid4 = 1'b0;
    logic       ready4, we4, clr4, en4, ov4, busy4;
    logic [1:0] waddr4, raddr4, craddr4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .input_valid(input_valid), .input_ready(input_ready),
        .sample_we(sample_we), .sample_waddr(sample_waddr),
        .sample_raddr(sample_raddr), .coef_raddr(coef_raddr),
        .acc_clr(acc_clr), .acc_en(acc_en),
        .output_valid(output_valid), .busy(busy)
    );

    fir_mac_sequencer #(.TAPS(4), .ADDR_W(2), .MAC_LAT(1)) dut4 (
        .clk(clk), .rst(rst), .clear(clear4),
        .input_valid(valid4), .input_ready(ready4),
        .sample_we(we4), .sample_waddr(waddr4),
        .sample_raddr(raddr4), .coef_raddr(craddr4),
        .acc_clr(clr4), .acc_en(en4),
        .output_valid(ov4), .busy(busy4)
    );

    typedef struct {
        bit hold;
        bit clr_before;
        bit clr_with;
        bit clr_mid;
        int exp_waddr;
        int exp_en;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_one(input int idx, input vec_t v);
        int en_cnt = 0;
        int first_en = -1;
        int ov_cyc = -1;
        int rd1 = -1;
        int bad_idle = 0;
        int overlap = 0;
        if (v.clr_before) begin
            @(negedge clk);
            input_valid = 1'b0;
            clear = 1'b1;
            #1;
        end
        @(negedge clk);
        input_valid = 1'b1;
        clear = v.clr_with;
        #1;
        chk($sformatf("v%0d ready0", idx), int'(input_ready), 1);
        chk($sformatf("v%0d we0", idx), int'(sample_we), 1);
        chk($sformatf("v%0d waddr", idx), int'(sample_waddr), v.exp_waddr);
        chk($sformatf("v%0d clr0", idx), int'(acc_clr), 1);
        for (int c = 1; c <= 40 && ov_cyc < 0; c++) begin
            @(negedge clk);
            input_valid = v.hold;
            clear = v.clr_mid && (c < 6);
            #1;
            if (acc_en) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
            end
            if (c == 2) rd1 = int'(sample_raddr);
            if (input_ready || sample_we || acc_clr) bad_idle++;
            if (acc_clr && acc_en) overlap++;
            if (output_valid) ov_cyc = c;
        end
        clear = 1'b0;
        chk($sformatf("v%0d ov_cycle", idx), ov_cyc, 19);
        chk($sformatf("v%0d en_count", idx), en_cnt, v.exp_en);
        chk($sformatf("v%0d first_en", idx), first_en, 3);
        chk($sformatf("v%0d raddr_tap1", idx), rd1, (v.exp_waddr + 15) % 16);
        chk($sformatf("v%0d busy_gating", idx), bad_idle, 0);
        chk($sformatf("v%0d clr_en_overlap", idx), overlap, 0);
    endtask

    task automatic run4(input int idx, input int ew, input int ee);
        int en_cnt = 0;
        int first_en = -1;
        int last_en = -1;
        int ov_cyc = -1;
        @(negedge clk);
        valid4 = 1'b1;
        #1;
        chk($sformatf("t4_%0d we0", idx), int'(we4), 1);
        chk($sformatf("t4_%0d waddr", idx), int'(waddr4), ew);
        for (int c = 1; c <= 20 && ov_cyc < 0; c++) begin
            @(negedge clk);
            valid4 = 1'b0;
            #1;
            if (en4) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
                last_en = c;
            end
            if (ov4) ov_cyc = c;
        end
        chk($sformatf("t4_%0d ov_cycle", idx), ov_cyc, 6);
        chk($sformatf("t4_%0d en_count", idx), en_cnt, ee);
        chk($sformatf("t4_%0d first_en", idx), first_en, 2);
        chk($sformatf("t4_%0d last_en", idx), last_en, 1 + ee);
    endtask

    initial begin
        int ov_seen;

        for (int i = 0; i < 20; i++) begin
            vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, i % 16,
                        (i + 1 > 16) ? 16 : i + 1};
        end
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 2};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3};

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst ready", int'(input_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst we", int'(sample_we), 0);
        chk("rst acc_clr", int'(acc_clr), 0);
        chk("rst acc_en", int'(acc_en), 0);
        chk("rst ov", int'(output_valid), 0);

        for (int i = 0; i < 25; i++) begin
            run_one(i, vecs[i]);
        end
        input_valid = 1'b0;

        @(negedge clk);
        input_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            input_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst busy", int'(busy), 0);
        chk("midrst ready", int'(input_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            #1;
            if (output_valid) ov_seen++;
        end
        chk("midrst no_ov", ov_seen, 0);
        run_one(99, '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1});

        run4(0, 0, 1);
        run4(1, 1, 2);
        run4(2, 2, 3);
        run4(3, 3, 4);
        run4(4, 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
